// File: rtl/keycode_led_display_if.sv
// Bundles the keycode input, debug vector, overflow clear and LED/status outputs of keycode_led_display.
// master: the keyboard front end or testbench, which drives keycode, keycode_valid, debug_in and clear_ovf.
// slave : the display block, which drives led, fifo_count, overflow and showing.
interface keycode_led_display_if #(
    parameter int LED_W  = 6,
    parameter int CODE_W = 16,
    parameter int DEPTH  = 4,
    parameter int DBG_W  = 3
);
    logic [CODE_W-1:0]       keycode;
    logic                    keycode_valid;
    logic [DBG_W-1:0]        debug_in;
    logic                    clear_ovf;
    logic [LED_W-1:0]        led;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;
    logic                    showing;

    modport master (
        output keycode, keycode_valid, debug_in, clear_ovf,
        input  led, fifo_count, overflow, showing
    );

    modport slave (
        input  keycode, keycode_valid, debug_in, clear_ovf,
        output led, fifo_count, overflow, showing
    );
endinterface

// File: rtl/keycode_led_display.sv
// Queues keycodes in a small FIFO and shows each one on the LEDs for HOLD_CYCLES cycles; while idle, shows a debug vector refreshed every IDLE_CYCLES.
// Latency: a keycode_valid rising edge is displayed two clock edges later at the earliest; led follows the display register with no extra delay.
// Backpressure: none. A push onto a full FIFO with no pop on that edge drops the new code and sets the sticky overflow flag.
// Ports: clk, reset (synchronous, active high); bus (slave modport) carrying keycode, keycode_valid, debug_in, clear_ovf in and led, fifo_count, overflow, showing out.
module keycode_led_display #(
    parameter int              LED_W          = 6,
    parameter int              CODE_W         = 16,
    parameter int              DEPTH          = 4,
    parameter int              HOLD_CYCLES    = 27000000,
    parameter int              IDLE_CYCLES    = 6750000,
    parameter int              DBG_W          = 3,
    parameter logic [LED_W-1:0] RESET_PATTERN = 6'b110011,
    parameter bit              LED_ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    keycode_led_display_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MAXC  = (HOLD_CYCLES > IDLE_CYCLES) ? HOLD_CYCLES : IDLE_CYCLES;
    localparam int TMR_W = $clog2(MAXC + 1);
    localparam int DAT_W = LED_W - 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_t;

    // Only the low DAT_W keycode bits ever reach the LEDs, so only those are stored.
    logic [DAT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prev_valid_q;
    logic             overflow_q, overflow_d;
    logic [LED_W-1:0] disp_q;
    logic [TMR_W-1:0] timer_q;
    state_t           state_q;

    logic             push, pop, wr_en, drop, fifo_empty, fifo_full, timer_zero;
    logic [DAT_W-1:0] head;
    logic [LED_W-1:0] dbg_ext;

    generate
        if (CODE_W > DAT_W) begin : g_code_hi
            logic unused_code_hi;
            assign unused_code_hi = ^bus.keycode[CODE_W-1:DAT_W];
        end
    endgenerate

    assign push       = bus.keycode_valid & ~prev_valid_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign timer_zero = (timer_q == '0);
    // IDLE pops as soon as anything is queued; SHOW pops only once the hold time has expired.
    assign pop        = ~fifo_empty & ((state_q == ST_IDLE) | timer_zero);
    // A pop on the same edge frees a slot, so a push onto a full FIFO still succeeds.
    assign wr_en      = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;
    assign head       = mem_q[rd_ptr_q];
    assign dbg_ext    = {{(LED_W-DBG_W){1'b0}}, bus.debug_in};

    assign count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    // Clear wins over a drop on the same edge.
    assign overflow_d = bus.clear_ovf ? 1'b0 : (overflow_q | drop);

    // Storage array needs no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.keycode[DAT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= TMR_W'(IDLE_CYCLES - 1);
            disp_q       <= RESET_PATTERN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            prev_valid_q <= bus.keycode_valid;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            // Pointer arithmetic wraps naturally because DEPTH is a power of two.
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_SHOW;
                        disp_q  <= {1'b1, head};
                        timer_q <= TMR_W'(HOLD_CYCLES - 1);
                    end else if (timer_zero) begin
                        disp_q  <= dbg_ext;
                        timer_q <= TMR_W'(IDLE_CYCLES - 1);
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (!timer_zero) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (pop) begin
                        disp_q  <= {1'b1, head};
                        timer_q <= TMR_W'(HOLD_CYCLES - 1);
                    end else begin
                        // Leaving SHOW touches only the flag and the debug bits; any
                        // middle bits keep the last keycode until the next idle refresh.
                        state_q              <= ST_IDLE;
                        disp_q[LED_W-1]      <= 1'b0;
                        disp_q[DBG_W-1:0]    <= bus.debug_in;
                        timer_q              <= TMR_W'(IDLE_CYCLES - 1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.led        = LED_ACTIVE_LOW ? ~disp_q : disp_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.showing    = (state_q == ST_SHOW);
endmodule

// File: tb/tb_keycode_led_display.sv
module tb_keycode_led_display;
    localparam int LED_W  = 6;
    localparam int CODE_W = 16;
    localparam int DEPTH  = 2;
    localparam int HOLD   = 10;
    localparam int IDLE   = 4;
    localparam int DBG_W  = 3;
    localparam logic [5:0] RST_PAT = 6'b110011;
    localparam logic [2:0] DBG     = 3'b101;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    keycode_led_display_if #(.LED_W(LED_W), .CODE_W(CODE_W), .DEPTH(DEPTH), .DBG_W(DBG_W)) ifc ();

    keycode_led_display #(
        .LED_W(LED_W), .CODE_W(CODE_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
        .IDLE_CYCLES(IDLE), .DBG_W(DBG_W), .RESET_PATTERN(RST_PAT), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int tests = 0;
    int fails = 0;
    logic [5:0] exp_q [$];

    // Monitor state
    logic       mon_in_run = 1'b0;
    logic [5:0] mon_led;
    int         mon_len;
    logic [5:0] mon_exp;
    logic       cnt_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [5:0] inv6(input logic [5:0] v);
        return ~v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] code);
        ifc.keycode       = code;
        ifc.keycode_valid = 1'b1;
        tick();
        ifc.keycode_valid = 1'b0;
        tick();
    endtask

    // Queue the active-low LED value a keycode should produce while displayed.
    task automatic expect_show(input logic [15:0] code);
        exp_q.push_back(inv6({1'b1, code[4:0]}));
    endtask

    // Monitor: measures each contiguous display (showing high, led constant) and scores it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_in_run = 1'b0;
            end else begin
                if (mon_in_run && !(ifc.showing === 1'b1 && ifc.led === mon_led)) begin
                    mon_in_run = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL display_unexpected: got led %b, expected no display", mon_led);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("display_led", mon_led, mon_exp);
                        check("display_len", mon_len, HOLD);
                    end
                end else if (mon_in_run) begin
                    mon_len++;
                end
                if (!mon_in_run && ifc.showing === 1'b1) begin
                    mon_in_run = 1'b1;
                    mon_led    = ifc.led;
                    mon_len    = 1;
                end
            end
        end
    end

    initial begin
        ifc.keycode       = '0;
        ifc.keycode_valid = 1'b0;
        ifc.debug_in      = DBG;
        ifc.clear_ovf     = 1'b0;
        reset             = 1'b1;

        // 1: reset state, pattern held until first idle refresh
        tick(); tick();
        check("rst_led", ifc.led, inv6(RST_PAT));
        check("rst_count", ifc.fifo_count, 0);
        check("rst_ovf", ifc.overflow, 0);
        check("rst_showing", ifc.showing, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("pattern_held", ifc.led, inv6(RST_PAT));
        tick();
        check("idle_refresh", ifc.led, inv6({3'b000, DBG}));

        // 2: single keycode, 2-edge latency, 10-cycle hold
        ifc.keycode = 16'h0015;
        expect_show(16'h0015);
        ifc.keycode_valid = 1'b1;
        tick();
        check("t2_showing_e1", ifc.showing, 0);
        check("t2_count_e1", ifc.fifo_count, 1);
        ifc.keycode_valid = 1'b0;
        tick();
        check("t2_showing_e2", ifc.showing, 1);
        check("t2_led", ifc.led, inv6(6'b110101));
        repeat (9) tick();
        check("t2_still_showing", ifc.showing, 1);
        tick();
        check("t2_idle", ifc.showing, 0);
        check("t2_exit_led", ifc.led, inv6({1'b0, 2'b10, DBG}));
        repeat (6) tick();
        check("t2_refresh", ifc.led, inv6({3'b000, DBG}));

        // 3: level held high enqueues once
        ifc.keycode = 16'h000A;
        expect_show(16'h000A);
        ifc.keycode_valid = 1'b1;
        tick();
        cnt_ok = 1'b1;
        repeat (29) begin
            tick();
            if (ifc.fifo_count !== 2'd0) cnt_ok = 1'b0;
        end
        check("t3_count_stays0", cnt_ok, 1);
        ifc.keycode_valid = 1'b0;
        repeat (5) tick();
        check("t3_idle", ifc.showing, 0);

        // 4: back-to-back display and overflow drop
        ifc.keycode = 16'h0000;
        expect_show(16'h0000);
        ifc.keycode_valid = 1'b1;
        tick();
        ifc.keycode_valid = 1'b0;
        tick();
        expect_show(16'h0001);
        pulse(16'h0001);
        expect_show(16'h0002);
        pulse(16'h0002);
        check("t4_count_full", ifc.fifo_count, 2);
        check("t4_ovf_before", ifc.overflow, 0);
        pulse(16'h0003);
        check("t4_ovf_set", ifc.overflow, 1);
        check("t4_count_kept", ifc.fifo_count, 2);
        repeat (30) tick();
        check("t4_ovf_sticky", ifc.overflow, 1);
        check("t4_idle", ifc.showing, 0);
        ifc.clear_ovf = 1'b1;
        tick();
        ifc.clear_ovf = 1'b0;
        check("t4_ovf_cleared", ifc.overflow, 0);

        // 5: push and pop on the same edge while full
        ifc.keycode = 16'h0004;
        expect_show(16'h0004);
        ifc.keycode_valid = 1'b1;
        tick();
        ifc.keycode_valid = 1'b0;
        tick();
        expect_show(16'h0005);
        pulse(16'h0005);
        expect_show(16'h0006);
        pulse(16'h0006);
        repeat (5) tick();
        check("t5_count_full", ifc.fifo_count, 2);
        ifc.keycode = 16'h0007;
        expect_show(16'h0007);
        ifc.keycode_valid = 1'b1;
        tick();
        check("t5_count_same", ifc.fifo_count, 2);
        check("t5_ovf_clear", ifc.overflow, 0);
        ifc.keycode_valid = 1'b0;
        repeat (35) tick();
        check("t5_idle", ifc.showing, 0);
        check("t5_drained", ifc.fifo_count, 0);

        // 6: reset mid-SHOW discards queue
        ifc.keycode = 16'h0008;
        ifc.keycode_valid = 1'b1;
        tick();
        ifc.keycode_valid = 1'b0;
        tick();
        pulse(16'h0009);
        pulse(16'h000A);
        check("t6_count_full", ifc.fifo_count, 2);
        check("t6_showing", ifc.showing, 1);
        reset = 1'b1;
        tick();
        check("t6_rst_led", ifc.led, inv6(RST_PAT));
        check("t6_rst_count", ifc.fifo_count, 0);
        check("t6_rst_showing", ifc.showing, 0);
        reset = 1'b0;
        repeat (20) tick();
        check("t6_no_show", ifc.showing, 0);
        check("t6_count0", ifc.fifo_count, 0);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
